// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier producing the full 2*XLEN-bit product of two XLEN-bit operands.
// Optional macro ALU_MUL_EARLY_OUT_EN ends iteration once the remaining multiplier bits are all zero.
`ifndef XLEN
`define XLEN 64
`endif

module alu_mul_seq #(
   parameter int unsigned XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_sr1_signed,
   input  logic            is_sr2_signed,
   input  logic [XLEN-1:0] sr1_data,
   input  logic [XLEN-1:0] sr2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mul_result_lo,
   output logic [XLEN-1:0] mul_result_hi
);

   localparam int unsigned PW = 2 * XLEN;
   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   prod_q;
   logic            neg_q;

   logic            accept_c;
   logic            last_iter_c;
   logic            sr1_neg_c;
   logic            sr2_neg_c;
   logic [XLEN-1:0] sr1_mag_c;
   logic [XLEN-1:0] sr2_mag_c;
   logic [PW-1:0]   acc_next_c;
   logic [XLEN-1:0] mplier_next_c;

   // Operand magnitudes; the most negative value maps onto itself, which is exact as unsigned
   assign sr1_neg_c = is_sr1_signed & sr1_data[XLEN-1];
   assign sr2_neg_c = is_sr2_signed & sr2_data[XLEN-1];
   assign sr1_mag_c = sr1_neg_c ? (~sr1_data + XLEN'(1)) : sr1_data;
   assign sr2_mag_c = sr2_neg_c ? (~sr2_data + XLEN'(1)) : sr2_data;

   assign accept_c      = in_valid && (state_q == S_IDLE) && !flush;
   assign acc_next_c    = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
   assign mplier_next_c = mplier_q >> 1;

`ifdef ALU_MUL_EARLY_OUT_EN
   assign last_iter_c = (cnt_q == CW'(XLEN - 1)) || (mplier_next_c == '0);
`else
   assign last_iter_c = (cnt_q == CW'(XLEN - 1));
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept_c) state_d = S_BUSY;
         S_BUSY: begin
            if (flush)            state_d = S_IDLE;
            else if (last_iter_c) state_d = S_DONE;
         end
         S_DONE: if (flush || out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decode registered state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: latch magnitudes on accept, shift-add while busy, sign-correct on the last step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         neg_q    <= 1'b0;
      end else if (accept_c) begin
         neg_q    <= sr1_neg_c ^ sr2_neg_c;
         mcand_q  <= PW'(sr1_mag_c);
         mplier_q <= sr2_mag_c;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if ((state_q == S_BUSY) && !flush) begin
         acc_q    <= acc_next_c;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_next_c;
         cnt_q    <= cnt_q + CW'(1);
         if (last_iter_c) begin
            prod_q <= neg_q ? (~acc_next_c + PW'(1)) : acc_next_c;
         end
      end
   end

   assign mul_result_lo = prod_q[XLEN-1:0];
   assign mul_result_hi = prod_q[PW-1:XLEN];

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle shift-add integer multiplier for the EX stage. It is the multiplicative counterpart of the combinational divider and covers the RV64M MUL/MULH/MULHSU/MULHU family (and MULW after sign-extension by the caller) using the same per-operand signedness controls. Operands enter through a valid/ready handshake, and the full 2·XLEN-bit product leaves through a second valid/ready handshake. The block accepts only one operation at a time, and `flush` discards any operation in flight on a pipeline kill.

## Interface
- `XLEN`, default from `` `XLEN `` (64): operand width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands and controls are valid.
- `in_ready` out 1: block can accept an operation. High only in IDLE.
- `is_sr1_signed` in 1: treat `sr1_data` as two's complement.
- `is_sr2_signed` in 1: treat `sr2_data` as two's complement.
- `sr1_data` in XLEN: multiplicand.
- `sr2_data` in XLEN: multiplier.
- `flush` in 1: abort the current operation and drop any pending result.
- `out_valid` out 1: result is valid. High only in DONE.
- `out_ready` in 1: consumer takes the result.
- `mul_result_lo` out XLEN: product bits [XLEN-1:0].
- `mul_result_hi` out XLEN: product bits [2·XLEN-1:XLEN].

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterating.
  - DONE: `out_valid`=1.
- Accept: `in_valid && in_ready && !flush` at a rising edge. On accept, the block latches:
  - `neg` = (`is_sr1_signed` & sr1[XLEN-1]) XOR (`is_sr2_signed` & sr2[XLEN-1]).
  - `mcand` = |sr1|, zero-extended to 2·XLEN. The magnitude is taken only if signed and negative.
  - `mplier` = |sr2|, XLEN bits.
  - `acc` = 0.
  - `cnt` = 0.
  - Next state is BUSY.
- BUSY, each cycle:
  - `acc` += `mplier[0]` ? `mcand` : 0.
  - `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
- End of iteration: the edge on which `cnt` reaches XLEN-1 is the final iteration. On that edge, the product register is loaded with `neg` ? −acc_next : acc_next (2·XLEN-bit two's complement), and the state moves to DONE.
- Magnitude of the most negative value: 2^(XLEN-1) fits in the unsigned XLEN-bit `mplier` and the 2·XLEN-bit `mcand`. No overflow case exists, and the product is exact for all 4 signedness combinations.
- DONE: outputs hold stable until `out_ready`. The edge with `out_valid && out_ready` moves the state to IDLE. A new operation is not accepted in the same cycle.
- `flush`:
  - Any state goes to IDLE on the next edge, and no `out_valid` follows.
  - `flush` together with `in_valid` in IDLE means no accept.
  - `flush` together with `out_ready` in DONE means the state goes to IDLE. The consumer must ignore that result.
- Reset (async, any time, including mid-BUSY):
  - state = IDLE.
  - `acc`, `mcand`, `mplier`, `cnt`, product register, and `neg` all = 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `mul_result_lo`=0, `mul_result_hi`=0.
- Inputs are sampled only at accept. Operand changes after accept have no effect.

## Timing
- Latency, measured from the accept edge E0: `out_valid` rises after edge E0+XLEN (64 cycles for XLEN=64), with macro off.
- Throughput: one operation per XLEN+2 cycles minimum when `out_ready` is held high. This covers accept, XLEN BUSY cycles, DONE, and the return to IDLE.
- `in_ready` and `out_valid` are registered-state decodes. They have no combinational path from `in_valid` or `out_ready`.
- `mul_result_*` are driven from registers. They are unchanged from the edge entering DONE until the next accept.

## Configuration
- `ALU_MUL_EARLY_OUT_EN`:
  - Defined: BUSY also terminates on the first edge where the shifted `mplier` (the value after this cycle's shift) is 0. Sign correction and the move to DONE are applied on that edge. Latency becomes 1 + index of the highest set bit of |sr2|, with a minimum of 1 cycle (`sr2`=0 or 1) and a maximum of XLEN.
  - Undefined: fixed XLEN BUSY cycles. The zero-detect logic is absent.
  - Results are bit-identical either way.

## Test plan
- Signed×signed: sr1=−3, sr2=5 → lo=0xFFFF_FFFF_FFFF_FFF1, hi=0xFFFF_FFFF_FFFF_FFFF. `out_valid` appears 64 cycles after accept with the macro off.
- Unsigned×unsigned: sr1=sr2=0xFFFF_FFFF_FFFF_FFFF → hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0001.
- Signed×unsigned (MULHSU): sr1=0xFFFF_FFFF_FFFF_FFFF (−1), sr2=2 → hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE. Most-negative case: sr1=sr2=0x8000_0000_0000_0000, both signed → hi=0x4000_0000_0000_0000, lo=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` stays 1, results stable, `in_ready`=0. Raise `out_ready` → IDLE next edge.
- Flush and reset: assert `flush` at BUSY cycle 10 → IDLE next edge, no `out_valid`, next operation 7×6=42 correct. Assert `rst` low mid-BUSY → all outputs at reset values immediately, IDLE after release.
- `ALU_MUL_EARLY_OUT_EN` defined: sr2=0 → DONE after 1 BUSY cycle, result 0. sr2=0x100, sr1=3 → 9 BUSY cycles, lo=0x300. sr2 negative signed → |sr2| governs latency.
